// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Shared constants for the universal shift register: operation-select
// encodings and a helper that classifies a mode as a shifting operation.
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;  // s_in enters at MSB
    localparam logic [2:0] MODE_SHL   = 3'b010;  // s_in enters at LSB
    localparam logic [2:0] MODE_SPLIT = 3'b011;  // s_in enters at centre, moves outward
    localparam logic [2:0] MODE_LOAD  = 3'b100;  // parallel load
    // 101..111 are treated as hold.

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_SPLIT);
    endfunction

endpackage

// File: rtl/shift_cell.sv
// -----------------------------------------------------------------------------
// shift_cell
// One bit of storage: a D flip-flop with synchronous reset (to 0) and
// synchronous preset (to 1), fed by a next-value mux selected by mode.
// Ports:
//   clk, reset, pre, en   - clock, sync reset, sync preset, enable
//   mode_i                - operation select
//   shr_i, shl_i, split_i - neighbour value for right / left / split shift
//   load_i                - parallel-load bit
//   q_o                   - stored bit
// -----------------------------------------------------------------------------
module shift_cell
    import shift_register_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pre,
    input  logic       en,
    input  logic [2:0] mode_i,
    input  logic       shr_i,
    input  logic       shl_i,
    input  logic       split_i,
    input  logic       load_i,
    output logic       q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (en) begin
            case (mode_i)
                MODE_SHR:   bit_d = shr_i;
                MODE_SHL:   bit_d = shl_i;
                MODE_SPLIT: bit_d = split_i;
                MODE_LOAD:  bit_d = load_i;
                default:    bit_d = bit_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    bit_q <= 1'b0;
        else if (pre) bit_q <= 1'b1;
        else          bit_q <= bit_d;
    end

    assign q_o = bit_q;

endmodule

// File: rtl/shift_register_nb_universal.sv
// -----------------------------------------------------------------------------
// shift_register_nb_universal
// WIDTH-bit universal shift register (hold / shift right / shift left /
// centre-out split / parallel load) with a completed-word strobe.
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - sync active-high reset (highest priority)
//   pre        - sync active-high preset, loads all ones
//   en         - enable; low holds all state
//   mode       - operation select (see shift_register_pkg)
//   s_in       - serial input
//   p_in       - parallel load data
//   out        - register contents
//   s_out      - last bit shifted off the register
//   word_valid - one-cycle strobe when a full word has been shifted in
// -----------------------------------------------------------------------------
module shift_register_nb_universal
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] out,
    output logic             s_out,
    output logic             word_valid
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [WIDTH-1:0] split_src;

    // Per-bit neighbour selection. In split mode the two centre bits take
    // s_in; the lower half moves toward bit 0, the upper half toward the MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_shr_edge
            assign shr_src[i] = s_in;
        end else begin : g_shr_mid
            assign shr_src[i] = out[i+1];
        end

        if (i == 0) begin : g_shl_edge
            assign shl_src[i] = s_in;
        end else begin : g_shl_mid
            assign shl_src[i] = out[i-1];
        end

        if (i == HALF - 1 || i == HALF) begin : g_split_ctr
            assign split_src[i] = s_in;
        end else if (i < HALF) begin : g_split_lo
            assign split_src[i] = out[i+1];
        end else begin : g_split_hi
            assign split_src[i] = out[i-1];
        end

        shift_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .pre     (pre),
            .en      (en),
            .mode_i  (mode),
            .shr_i   (shr_src[i]),
            .shl_i   (shl_src[i]),
            .split_i (split_src[i]),
            .load_i  (p_in[i]),
            .q_o     (out[i])
        );
    end

    // Word tracking and serial output.
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          word_valid_q, word_valid_d;
    logic          s_out_q, s_out_d;
    logic [CW-1:0] last_idx;   // target - 1 for the current mode

    assign last_idx = (mode == MODE_SPLIT) ? CW'(HALF - 1) : CW'(WIDTH - 1);

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        s_out_d      = s_out_q;
        word_valid_d = 1'b0;      // strobe lasts a single cycle
        if (en) begin
            case (mode)
                MODE_SHR, MODE_SPLIT: s_out_d = out[0];
                MODE_SHL:             s_out_d = out[WIDTH-1];
                default:              s_out_d = s_out_q;
            endcase
            if (is_shift_mode(mode)) begin
                // >= so a switch to split with a count already past its
                // shorter target still completes and wraps.
                if (bit_cnt_q >= last_idx) begin
                    bit_cnt_d    = '0;
                    word_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end else if (mode == MODE_LOAD) begin
                bit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || pre) begin
            bit_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            s_out_q      <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            word_valid_q <= word_valid_d;
            s_out_q      <= s_out_d;
        end
    end

    assign s_out      = s_out_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_shift_register_nb_universal.sv
module tb_shift_register_nb_universal;

    logic       clk = 1'b0;
    logic       reset, pre, en, s_in;
    logic [2:0] mode;
    logic [7:0] p_in;
    logic [7:0] out;
    logic       s_out, word_valid;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [7:0] m_out;
    logic       m_so, m_wv;
    int         m_cnt;

    shift_register_nb_universal #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .pre(pre), .en(en), .mode(mode),
        .s_in(s_in), .p_in(p_in), .out(out), .s_out(s_out),
        .word_valid(word_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each operation computed from the rules with plain arithmetic.
    task automatic model_step(input logic r, input logic p, input logic e,
                              input logic [2:0] m, input logic s, input logic [7:0] pi);
        int lo, hi, tgt;
        if (r) begin
            m_out = 0; m_so = 0; m_wv = 0; m_cnt = 0;
        end else if (p) begin
            m_out = 8'hFF; m_so = 0; m_wv = 0; m_cnt = 0;
        end else if (e && m >= 1 && m <= 3) begin
            if (m == 1) begin
                m_so  = m_out[0];
                m_out = (m_out >> 1) | (8'(s) << 7);
            end else if (m == 2) begin
                m_so  = m_out[7];
                m_out = (m_out << 1) | 8'(s);
            end else begin
                m_so = m_out[0];
                lo = (int'(m_out) % 16) / 2 + int'(s) * 8;
                hi = ((int'(m_out) / 16) * 2 + int'(s)) % 16;
                m_out = 8'(hi * 16 + lo);
            end
            tgt = (m == 3) ? 4 : 8;
            m_cnt = m_cnt + 1;
            if (m_cnt >= tgt) begin m_cnt = 0; m_wv = 1; end
            else m_wv = 0;
        end else if (e && m == 4) begin
            m_out = pi; m_cnt = 0; m_wv = 0;
        end else begin
            m_wv = 0;
        end
    endtask

    // Drive one cycle, advance the model, and compare every output.
    task automatic cyc(input logic r, input logic p, input logic e,
                       input logic [2:0] m, input logic s, input logic [7:0] pi);
        reset = r; pre = p; en = e; mode = m; s_in = s; p_in = pi;
        @(posedge clk);
        #1;
        model_step(r, p, e, m, s, pi);
        chk("out", int'(out), int'(m_out));
        chk("s_out", int'(s_out), int'(m_so));
        chk("word_valid", int'(word_valid), int'(m_wv));
        chk("bit_cnt", int'(dut.bit_cnt_q), m_cnt);
    endtask

    logic [7:0] seq;
    logic [7:0] held;

    initial begin
        reset = 1; pre = 0; en = 0; mode = 0; s_in = 0; p_in = 0;
        #2;

        // reset with arbitrary other inputs
        cyc(1, 0, 1, 3'b001, 1, 8'h5A);
        chk("lit_reset_out", int'(out), 8'h00);
        chk("lit_reset_wv", int'(word_valid), 0);

        // shift right 1,0,1,1,0,0,1,0
        seq = 8'b0100_1101;  // bit k = k-th serial bit
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1, 3'b001, seq[k], 8'h00);
            if (k < 7) chk("lit_shr_no_strobe", int'(word_valid), 0);
        end
        chk("lit_shr_out", int'(out), 8'h4D);
        chk("lit_shr_strobe", int'(word_valid), 1);
        cyc(0, 0, 0, 3'b000, 0, 8'h00);
        chk("lit_shr_strobe_drop", int'(word_valid), 0);

        // split from zero
        cyc(1, 0, 0, 3'b000, 0, 8'h00);
        cyc(0, 0, 1, 3'b011, 1, 8'h00);
        cyc(0, 0, 1, 3'b011, 1, 8'h00);
        chk("lit_split2_out", int'(out), 8'h3C);
        chk("lit_split2_wv", int'(word_valid), 0);
        cyc(0, 0, 1, 3'b011, 1, 8'h00);
        chk("lit_split3_wv", int'(word_valid), 0);
        cyc(0, 0, 1, 3'b011, 1, 8'h00);
        chk("lit_split4_out", int'(out), 8'hFF);
        chk("lit_split4_wv", int'(word_valid), 1);

        // load then shift left
        cyc(0, 0, 1, 3'b100, 0, 8'hA5);
        chk("lit_load_out", int'(out), 8'hA5);
        chk("lit_load_wv", int'(word_valid), 0);
        cyc(0, 0, 1, 3'b010, 0, 8'h00);
        chk("lit_shl_out", int'(out), 8'h4A);
        chk("lit_shl_sout", int'(s_out), 1);

        // priority
        cyc(0, 0, 1, 3'b001, 1, 8'h00);
        cyc(1, 1, 1, 3'b100, 1, 8'h77);
        chk("lit_rst_over_pre", int'(out), 8'h00);
        cyc(0, 0, 1, 3'b001, 1, 8'h00);
        cyc(0, 0, 1, 3'b001, 1, 8'h00);
        cyc(0, 1, 1, 3'b010, 0, 8'h00);
        chk("lit_pre_out", int'(out), 8'hFF);
        chk("lit_pre_cnt", int'(dut.bit_cnt_q), 0);
        held = out;
        cyc(0, 0, 0, 3'b001, 0, 8'h00);
        chk("lit_en0_hold", int'(out), int'(held));

        // mid-word reset discards partial count
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 3'b001, 1, 8'h00);
        cyc(1, 0, 0, 3'b000, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1, 3'b001, k[0], 8'h00);
            chk("lit_midword_wv", int'(word_valid), (k == 7) ? 1 : 0);
        end

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                1'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_register_nb_universal.md
SHIFT_REGISTER_NB_UNIVERSAL -- requirements
Module: shift_register_nb_universal

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; SHALL be even and >= 2.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port pre  input  1  synchronous, active-high preset; loads all ones into the register.
REQ-005 Port en  input  1  shift/load enable; when low, all state SHALL hold.
REQ-006 Port mode  input  3  operation select (see REQ-010).
REQ-007 Port s_in  input  1  serial data input.
REQ-008 Port p_in  input  WIDTH  parallel load data.
REQ-009 Ports out  output  WIDTH  register contents; s_out  output  1  last bit shifted off; word_valid  output  1  one-cycle completed-word strobe.

Function
REQ-010 mode encoding SHALL be:
- 000 hold
- 001 shift right: s_in -> out[WIDTH-1], out[i] <- out[i+1]
- 010 shift left: s_in -> out[0], out[i] <- out[i-1]
- 011 split (centre-out): s_in -> out[WIDTH/2-1] shifting toward out[0], and s_in -> out[WIDTH/2] shifting toward out[WIDTH-1]
- 100 parallel load: out <- p_in
- 101..111 hold
REQ-011 Edge priority SHALL be reset > pre > (en and mode).
REQ-012 s_out SHALL register the bit displaced on each shift: old out[0] for 001 and 011; old out[WIDTH-1] for 010. s_out SHALL hold on all other cycles.
REQ-013 Shift counter bit_cnt, width $clog2(WIDTH+1), SHALL:
- increment by 1 on each enabled shift (001/010/011)
- hold on hold modes and when en=0
- clear on parallel load, pre and reset.
REQ-014 Target SHALL be WIDTH for modes 001/010 and WIDTH/2 for mode 011.
REQ-015 On an enabled shift with bit_cnt >= target-1:
- word_valid SHALL be 1 in the following cycle (registered, same edge as the completing shift)
- bit_cnt SHALL wrap to 0.
REQ-016 word_valid SHALL be high for exactly one cycle per completed word and 0 otherwise, including on load and pre.
REQ-017 A mode change between shift modes SHALL NOT clear bit_cnt; the new mode's target applies from that cycle.
REQ-018 Latency: out, s_out and word_valid SHALL reflect an operation one clock after the edge that samples it; no combinational path from inputs to outputs.

Reset
REQ-019 reset=1 at an edge SHALL set out=0, s_out=0, word_valid=0, bit_cnt=0, regardless of pre, en and mode.
REQ-020 pre=1 with reset=0 SHALL set out={WIDTH{1'b1}}, s_out=0, word_valid=0, bit_cnt=0.
REQ-021 Reset asserted mid-word SHALL discard the partial count; the next word_valid SHALL require a full target count of shifts.

Structure
REQ-022 Mode encodings SHALL be named constants in shared package shift_register_pkg.
REQ-023 Per-bit storage SHALL be one sub-module, shift_cell: a sync reset/preset D flip-flop with a next-value mux, instantiated WIDTH times via generate.
REQ-024 bit_cnt, word_valid and s_out logic SHALL reside in the top module.

Verification (WIDTH=8)
REQ-025 Reset: reset=1 for 1 clock, any inputs -> out=8'h00, s_out=0, word_valid=0.
REQ-026 Shift right: mode=001, en=1, s_in=1,0,1,1,0,0,1,0 over 8 clocks -> out=8'h4D; word_valid=1 for exactly the cycle after the 8th edge.
REQ-027 Split: from out=0, mode=011, s_in=1:
- after 2 clocks -> out=8'h3C, no strobe
- after 4 clocks -> out=8'hFF, word_valid pulses once.
REQ-028 Load then shift left:
- mode=100, p_in=8'hA5 -> out=8'hA5
- then mode=010, s_in=0, 1 clock -> out=8'h4A, s_out=1.
REQ-029 Priority:
- reset=1 with pre=1 -> out=8'h00
- pre=1 alone -> out=8'hFF, bit_cnt cleared
- en=0 with mode=001 -> out unchanged.
REQ-030 Mid-word reset: 5 shifts, reset, then 8 shifts (mode=001) -> word_valid only after the 8th post-reset shift, never earlier.
